// File: rtl/pxs_score_overlay_multi.sv
// pxs_score_overlay_multi
//   Pixel-stream overlay that draws two players' scores as NDIGITS decimal
//   digits, each an 8x8 glyph scaled by 2^SCALE_LOG2. The binary scores are
//   sampled at end of frame and converted to BCD during vertical blanking by a
//   sequential double-dabble FSM. Both players are converted in parallel. The
//   displayed digits change only when the conversion commits, so a frame is
//   never drawn with a mix of old and new digits. The 10-glyph bitmap is built
//   into the module as a constant table.
//
// Ports
//   px_clk     in   1        pixel clock
//   rst_n      in   1        asynchronous active-low reset
//   score1     in   SCORE_W  player 1 binary score, sampled only at endframe
//   score2     in   SCORE_W  player 2 binary score, sampled only at endframe
//   overlay_en in   1        0 = RGB forwarded unmodified (same latency)
//   RGBStr_i   in   26       {RGB[25:23], XC[22:13], YC[12:3], HS, VS, Active}
//   RGBStr_o   out  26       same format, delayed 2 cycles
//   busy       out  1        high while the BCD conversion runs
module pxs_score_overlay_multi #(
  parameter int         NDIGITS     = 2,
  parameter int         SCORE_W     = 8,
  parameter int         SCALE_LOG2  = 2,
  parameter int         P1X         = 128,
  parameter int         P2X         = 448,
  parameter int         POSY        = 32,
  parameter int         STRIDE      = 4,
  parameter logic [2:0] INK1        = 3'b101,
  parameter logic [2:0] INK2        = 3'b010,
  parameter bit         BLANK_LZ    = 1'b1,
  parameter int         VISIBLECOLS = 640,
  parameter int         VISIBLEROWS = 480
) (
  input  logic               px_clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score1,
  input  logic [SCORE_W-1:0] score2,
  input  logic               overlay_en,
  input  logic [25:0]        RGBStr_i,
  output logic [25:0]        RGBStr_o,
  output logic               busy
);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int          BOX     = 8 << SCALE_LOG2;
  localparam int          PITCH   = BOX + STRIDE;
  localparam int          DW      = 4 * NDIGITS;
  localparam int          CW      = $clog2(SCORE_W + 1);
  localparam logic [31:0] SAT_MAX = 32'(pow10(NDIGITS) - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;

  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] digit;
    logic [2:0] row;
    logic [2:0] col;
  } loc_t;

  // Glyph rows are stored top row first, leftmost pixel in the MSB of each
  // byte, so pixel (row,col) sits at bit 63-{row,col} = ~{row,col}.
  function automatic logic glyph_bit(input logic [3:0] d, input logic [2:0] row,
                                     input logic [2:0] col);
    logic [63:0] g;
    case (d)
      4'd0:    g = 64'h3C666E7666663C00;
      4'd1:    g = 64'h183818181818_7E00;
      4'd2:    g = 64'h3C66060C30607E00;
      4'd3:    g = 64'h3C66061C06663C00;
      4'd4:    g = 64'h0C1C3C6C7E0C0C00;
      4'd5:    g = 64'h7E607C0606663C00;
      4'd6:    g = 64'h3C607C6666663C00;
      4'd7:    g = 64'h7E060C1818181800;
      4'd8:    g = 64'h3C66663C66663C00;
      4'd9:    g = 64'h3C66663E060C3800;
      default: g = '0;
    endcase
    return g[~{row, col}];
  endfunction

  // Scores beyond the displayable range are clamped to all nines.
  function automatic logic over_range(input logic [SCORE_W-1:0] s);
    return 32'(s) > SAT_MAX;
  endfunction

  // One double-dabble step: correct every nibble >= 5, then shift in a bit.
  function automatic logic [DW-1:0] dabble_step(input logic [DW-1:0] acc,
                                                input logic in_bit);
    logic [DW-1:0] adj;
    adj = acc;
    for (int i = 0; i < NDIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    return {adj[DW-2:0], in_bit};
  endfunction

  // Finds which digit box of one player (if any) covers the pixel. Digit 0 is
  // the most significant and sits leftmost; lz tracks "this digit and every
  // more significant one is zero" for leading-zero blanking.
  function automatic loc_t locate(input logic [9:0] xc, input logic [9:0] yc,
                                  input int px, input logic [DW-1:0] disp);
    loc_t       l;
    logic [9:0] x0;
    logic       lz;
    l  = '0;
    lz = 1'b1;
    for (int k = 0; k < NDIGITS; k++) begin
      x0 = 10'(px + k * PITCH);
      lz = lz && (disp[DW-1-4*k -: 4] == 4'd0);
      if (xc >= x0 && xc < 10'(px + k * PITCH + BOX) &&
          yc >= 10'(POSY) && yc < 10'(POSY + BOX)) begin
        l.hit   = 1'b1;
        l.digit = disp[DW-1-4*k -: 4];
        l.blank = BLANK_LZ && (k < NDIGITS - 1) && lz;
        l.row   = 3'((yc - 10'(POSY)) >> SCALE_LOG2);
        l.col   = 3'((xc - x0) >> SCALE_LOG2);
      end
    end
    return l;
  endfunction

  logic [9:0]         xc, yc;
  logic               endframe;
  loc_t               loc1, loc2;

  logic [25:0]        str_p1, str_p2;
  logic               en_p1, ink1_p1, ink2_p1;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [SCORE_W-1:0] sh1, sh2;
  logic               sat1, sat2;
  logic [DW-1:0]      bcd1, bcd2;
  logic [DW-1:0]      disp1, disp2;

  assign xc       = RGBStr_i[22:13];
  assign yc       = RGBStr_i[12:3];
  assign endframe = (xc == 10'(VISIBLECOLS - 1)) && (yc == 10'(VISIBLEROWS - 1));

  always_comb begin
    loc1 = locate(xc, yc, P1X, disp1);
    loc2 = locate(xc, yc, P2X, disp2);
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      str_p1  <= '0;
      en_p1   <= 1'b0;
      ink1_p1 <= 1'b0;
      ink2_p1 <= 1'b0;
      str_p2  <= '0;
    end else begin
      // Stage 1: box hit + blanking, registered glyph ROM read
      str_p1  <= RGBStr_i;
      en_p1   <= overlay_en;
      ink1_p1 <= loc1.hit && !loc1.blank && glyph_bit(loc1.digit, loc1.row, loc1.col);
      ink2_p1 <= loc2.hit && !loc2.blank && glyph_bit(loc2.digit, loc2.row, loc2.col);
      // Stage 2: colour select, player 1 wins where the fields overlap
      str_p2[22:0] <= str_p1[22:0];
      if (en_p1 && ink1_p1)      str_p2[25:23] <= INK1;
      else if (en_p1 && ink2_p1) str_p2[25:23] <= INK2;
      else                       str_p2[25:23] <= str_p1[25:23];
    end
  end

  assign RGBStr_o = str_p2;

  // Conversion runs entirely in blanking; an endframe seen outside IDLE is
  // dropped rather than restarting the conversion.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      sh1   <= '0;
      sh2   <= '0;
      sat1  <= 1'b0;
      sat2  <= 1'b0;
      bcd1  <= '0;
      bcd2  <= '0;
      disp1 <= '0;
      disp2 <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (endframe) begin
            sh1   <= score1;
            sh2   <= score2;
            sat1  <= over_range(score1);
            sat2  <= over_range(score2);
            busy  <= 1'b1;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          bcd1  <= '0;
          bcd2  <= '0;
          cnt   <= CW'(SCORE_W);
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          bcd1 <= dabble_step(bcd1, sh1[SCORE_W-1]);
          bcd2 <= dabble_step(bcd2, sh2[SCORE_W-1]);
          sh1  <= sh1 << 1;
          sh2  <= sh2 << 1;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= S_COMMIT;
        end
        S_COMMIT: begin
          disp1 <= sat1 ? {NDIGITS{4'h9}} : bcd1;
          disp2 <= sat2 ? {NDIGITS{4'h9}} : bcd2;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pxs_score_overlay_multi.sv
// Testbench for pxs_score_overlay_multi: table-driven pixel vectors plus a
// behavioural overlay model feeding a scoreboard queue, with hand-written
// sequences for busy timing, saturation, frame atomicity and async reset.
module tb_pxs_score_overlay_multi;

  localparam int         NDIG   = 2;
  localparam int         SW     = 8;
  localparam int         SC     = 2;
  localparam int         P1X    = 128;
  localparam int         P2X    = 448;
  localparam int         POSY   = 32;
  localparam int         STRIDE = 4;
  localparam logic [2:0] INK1   = 3'b101;
  localparam logic [2:0] INK2   = 3'b010;
  localparam int         BOX    = 8 << SC;
  localparam int         PITCH  = BOX + STRIDE;

  logic          px_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] score1 = '0;
  logic [SW-1:0] score2 = '0;
  logic          overlay_en = 1'b0;
  logic [25:0]   RGBStr_i = '0;
  logic [25:0]   RGBStr_o;
  logic          busy;

  always #5 px_clk = ~px_clk;

  pxs_score_overlay_multi #(
    .NDIGITS(NDIG), .SCORE_W(SW), .SCALE_LOG2(SC), .P1X(P1X), .P2X(P2X),
    .POSY(POSY), .STRIDE(STRIDE), .INK1(INK1), .INK2(INK2), .BLANK_LZ(1'b1),
    .VISIBLECOLS(640), .VISIBLEROWS(480)
  ) u_dut (
    .px_clk(px_clk), .rst_n(rst_n), .score1(score1), .score2(score2),
    .overlay_en(overlay_en), .RGBStr_i(RGBStr_i), .RGBStr_o(RGBStr_o), .busy(busy)
  );

  typedef struct { logic [25:0] exp; string name; } sb_t;
  typedef struct { logic [2:0] rgb; int x; int y; logic en; logic [2:0] exp; string name; } vec_t;

  sb_t  sbq[$];
  vec_t tv0[12];
  vec_t tv1[6];
  int   checks = 0;
  int   failures = 0;
  int   m_val1 = 0, m_val2 = 0, n_val1 = 0, n_val2 = 0, pend = 0;
  int   bcnt;

  function automatic vec_t mk(input logic [2:0] rgb, input int x, input int y,
                              input logic en, input logic [2:0] exp, input string name);
    vec_t v;
    v.rgb = rgb; v.x = x; v.y = y; v.en = en; v.exp = exp; v.name = name;
    return v;
  endfunction

  function automatic logic [63:0] font(input int d);
    case (d)
      0: return 64'h3C666E7666663C00;
      1: return 64'h1838181818187E00;
      2: return 64'h3C66060C30607E00;
      3: return 64'h3C66061C06663C00;
      4: return 64'h0C1C3C6C7E0C0C00;
      5: return 64'h7E607C0606663C00;
      6: return 64'h3C607C6666663C00;
      7: return 64'h7E060C1818181800;
      8: return 64'h3C66663C66663C00;
      default: return 64'h3C66663E060C3800;
    endcase
  endfunction

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int shown(input int s);
    return (s > p10(NDIG) - 1) ? p10(NDIG) - 1 : s;
  endfunction

  // Digit k of value val is drawn unless it is a leading zero (val < 10^(N-1-k)).
  function automatic logic model_hit(input int val, input int px, input int x, input int y);
    int dx, k, w, pw;
    logic [63:0] g;
    if (x < px || y < POSY || y >= POSY + BOX) return 1'b0;
    dx = x - px; k = dx / PITCH; w = dx % PITCH;
    if (k >= NDIG || w >= BOX) return 1'b0;
    pw = p10(NDIG - 1 - k);
    if (k < NDIG - 1 && val < pw) return 1'b0;
    g = font((val / pw) % 10);
    return g[63 - (((y - POSY) >> SC) * 8 + (w >> SC))];
  endfunction

  function automatic logic [2:0] model_rgb(input logic [2:0] rgb, input int x, input int y,
                                           input logic en);
    if (en && model_hit(m_val1, P1X, x, y)) return INK1;
    if (en && model_hit(m_val2, P2X, x, y)) return INK2;
    return rgb;
  endfunction

  task automatic chk26(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // One pixel: entered at a negedge, drives the pixel, queues its expected
  // output and compares the output belonging to the pixel two cycles back.
  task automatic cyc(input logic [2:0] rgb, input int x, input int y, input logic [2:0] ctl,
                     input logic en, input logic use_model, input logic [2:0] exp_rgb,
                     input string name);
    sb_t e;
    logic [25:0] stim;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin m_val1 = n_val1; m_val2 = n_val2; end
    end
    stim = {rgb, 10'(x), 10'(y), ctl};
    e.exp = {use_model ? model_rgb(rgb, x, y, en) : exp_rgb, 10'(x), 10'(y), ctl};
    e.name = name;
    if (x == 639 && y == 479 && pend == 0) begin
      n_val1 = shown(int'(score1)); n_val2 = shown(int'(score2)); pend = 11;
    end
    RGBStr_i = stim;
    overlay_en = en;
    sbq.push_back(e);
    @(posedge px_clk); #1;
    if (sbq.size() >= 2) begin
      e = sbq.pop_front();
      chk26(e.name, RGBStr_o, e.exp);
    end
    @(negedge px_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'($urandom_range(0, 7)), 700, 500, 3'b011, 1'b1, 1'b1, 3'b000, "idle");
  endtask

  task automatic endframe();
    cyc(3'b000, 639, 479, 3'b000, 1'b1, 1'b1, 3'b000, "endframe");
  endtask

  task automatic scan(input string tag);
    for (int y = 30; y <= 66; y += 2) begin
      for (int x = 124; x <= 200; x++) cyc(3'($urandom_range(0, 7)), x, y, 3'b001, 1'b1, 1'b1, 3'b000, tag);
      for (int x = 444; x <= 520; x++) cyc(3'($urandom_range(0, 7)), x, y, 3'b001, 1'b1, 1'b1, 3'b000, tag);
    end
  endtask

  task automatic run_table0();
    foreach (tv0[i]) cyc(tv0[i].rgb, tv0[i].x, tv0[i].y, 3'b101, tv0[i].en, 1'b0, tv0[i].exp, tv0[i].name);
    idle(2);
  endtask

  task automatic restart_model();
    sbq.delete();
    m_val1 = 0; m_val2 = 0; pend = 0;
  endtask

  initial begin
    tv0[0]  = mk(3'b000, 172, 32, 1'b1, 3'b101, "lsd0_r0c2");
    tv0[1]  = mk(3'b011, 164, 32, 1'b1, 3'b011, "lsd0_r0c0");
    tv0[2]  = mk(3'b110, 136, 32, 1'b1, 3'b110, "p1_msd_blank");
    tv0[3]  = mk(3'b001, 161, 36, 1'b1, 3'b001, "p1_gap");
    tv0[4]  = mk(3'b111, 492, 32, 1'b1, 3'b010, "p2_lsd0");
    tv0[5]  = mk(3'b100, 172, 31, 1'b1, 3'b100, "above_box");
    tv0[6]  = mk(3'b100, 172, 64, 1'b1, 3'b100, "below_box");
    tv0[7]  = mk(3'b011, 172, 32, 1'b0, 3'b011, "overlay_off");
    tv0[8]  = mk(3'b000, 168, 36, 1'b1, 3'b101, "lsd0_r1c1");
    tv0[9]  = mk(3'b110, 176, 36, 1'b1, 3'b110, "lsd0_r1c3");
    tv0[10] = mk(3'b101, 456, 32, 1'b1, 3'b101, "p2_msd_blank");
    tv0[11] = mk(3'b000, 195, 63, 1'b1, 3'b000, "lsd0_r7c7");
    tv1[0]  = mk(3'b000, 144, 52, 1'b1, 3'b101, "g4_r5c4");
    tv1[1]  = mk(3'b011, 128, 52, 1'b1, 3'b011, "g4_r5c0");
    tv1[2]  = mk(3'b100, 456, 32, 1'b1, 3'b100, "p2_msd_blank9");
    tv1[3]  = mk(3'b000, 492, 32, 1'b1, 3'b010, "g9_r0c2");
    tv1[4]  = mk(3'b000, 168, 32, 1'b1, 3'b101, "g7_r0c1");
    tv1[5]  = mk(3'b111, 160, 52, 1'b1, 3'b111, "gap_47");

    // Reset held with live stimulus
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RGBStr_i = 26'($urandom);
      overlay_en = 1'b1;
      @(posedge px_clk); #1;
      chk26("reset_out", RGBStr_o, 26'd0);
      chk_int("reset_busy", int'(busy), 0);
      @(negedge px_clk);
    end
    rst_n = 1'b1;
    restart_model();

    // Digits from reset are all zero: single "0" per player
    run_table0();
    scan("reset_frame");

    // Passthrough with overlay disabled, fully random stream
    for (int i = 0; i < 300; i++)
      cyc(3'($urandom_range(0, 7)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
          3'($urandom_range(0, 7)), 1'b0, 1'b1, 3'b000, "passthrough");
    idle(14);

    // Conversion 47 / 9, busy exactly SCORE_W+2 cycles
    score1 = 8'd47; score2 = 8'd9;
    chk_int("busy_before", int'(busy), 0);
    endframe();
    chk_int("busy_rise", int'(busy), 1);
    bcnt = int'(busy);
    for (int i = 0; i < 14; i++) begin idle(1); bcnt += int'(busy); end
    chk_int("busy_len_47", bcnt, SW + 2);
    foreach (tv1[i]) cyc(tv1[i].rgb, tv1[i].x, tv1[i].y, 3'b010, tv1[i].en, 1'b0, tv1[i].exp, tv1[i].name);
    idle(2);
    scan("conv_47_9");

    // Saturation of out-of-range scores; 99 itself is in range
    for (int s = 0; s < 3; s++) begin
      score1 = (s == 0) ? 8'd255 : (s == 1) ? 8'd100 : 8'd99;
      score2 = (s == 0) ? 8'd100 : 8'd5;
      endframe();
      idle(12);
      cyc(3'b000, 148, 56, 3'b000, 1'b1, 1'b0, 3'b000, "sat_msd9_r6c5");
      cyc(3'b000, 188, 44, 3'b000, 1'b1, 1'b0, INK1, "sat_lsd9_r3c6");
      idle(2);
      scan("saturation");
    end

    // Frame atomicity: a mid-frame score change waits for the next endframe
    score1 = 8'd12; score2 = 8'd0;
    endframe();
    idle(12);
    scan("frame_12");
    score1 = 8'd34;
    scan("frame_12_held");
    endframe();
    idle(12);
    scan("frame_34");

    // Second endframe while busy is ignored
    score1 = 8'd56;
    endframe();
    bcnt = int'(busy);
    score1 = 8'd78;
    endframe();
    bcnt += int'(busy);
    for (int i = 0; i < 12; i++) begin idle(1); bcnt += int'(busy); end
    chk_int("busy_len_ignore", bcnt, SW + 2);
    scan("frame_56");

    // Asynchronous reset in the middle of SHIFT
    score1 = 8'd88; score2 = 8'd77;
    endframe();
    idle(2);
    chk_int("busy_mid_shift", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_int("async_rst_busy", int'(busy), 0);
    chk26("async_rst_out", RGBStr_o, 26'd0);
    @(negedge px_clk);
    rst_n = 1'b1;
    restart_model();
    run_table0();
    scan("after_async_rst");
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
